led_blink_ctrl: RTL and testbench

//  Multi-channel programmable LED blinker; parametrised successor of the fixed 1 Hz / 50% LED divider.
//  One shared prescaler derives a TICK from CLK; each channel runs its own period/on-time phase counter.
//  Per-channel mode and timing are written through a single-cycle config port and applied glitch-free at period boundaries.

---
 rtl/led_blink_pkg.sv | 25 ++
 rtl/led_blink_chan.sv | 76 +++++++
 rtl/led_blink_ctrl.sv | 93 +++++++++
 tb/tb_led_blink_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_blink_pkg.sv
// Shared types for the multi-channel LED blinker: channel modes, channel config
// record and the prescaler divide calculation.
package led_blink_pkg;

    // Config fields are carried at a fixed width; channels use only the low CNT_W bits.
    localparam int CFG_W = 32;

    typedef enum logic [1:0] {
        LED_OFF     = 2'd0,
        LED_ON      = 2'd1,
        LED_BLINK   = 2'd2,
        LED_ONESHOT = 2'd3
    } led_mode_t;

    typedef struct packed {
        led_mode_t          mode;
        logic [CFG_W-1:0]   period;
        logic [CFG_W-1:0]   on;
    } chan_cfg_t;

    function automatic int pre_div_calc(input int clk_hz, input int tick_hz);
        return clk_hz / tick_hz;
    endfunction

endpackage

// File: rtl/led_blink_chan.sv
// One LED channel: active and pending config, tick-driven phase counter and the
// registered LED bit. New config lands at a period boundary, or at once when OFF.
module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_step,
    input  logic      i_sync,
    input  logic      i_wr,
    input  chan_cfg_t i_cfg,
    output logic      o_led
);

    chan_cfg_t          r_act;
    chan_cfg_t          r_pend;
    logic               r_pend_v;
    logic [CNT_W-1:0]   r_phase;
    logic               r_led;

    logic [CFG_W-1:0]   w_last;
    logic               w_boundary;

    // A period of 0 behaves as 1: every tick is a boundary.
    assign w_last     = (r_act.period == '0) ? '0 : r_act.period - CFG_W'(1);
    assign w_boundary = (r_act.mode != LED_OFF) &&
                        (i_sync || (i_step && (CFG_W'(r_phase) == w_last)));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act    <= '0;
            r_pend   <= '0;
            r_pend_v <= 1'b0;
            r_phase  <= '0;
            r_led    <= 1'b0;
        end else begin
            // LED follows the state as it stood before this edge.
            case (r_act.mode)
                LED_OFF: r_led <= 1'b0;
                LED_ON:  r_led <= 1'b1;
                default: r_led <= (CFG_W'(r_phase) < r_act.on);
            endcase

            if (r_act.mode == LED_OFF) begin
                if (i_wr) begin
                    r_act   <= i_cfg;
                    r_phase <= '0;
                end
                r_pend_v <= 1'b0;
            end else if (w_boundary) begin
                r_phase  <= '0;
                r_pend_v <= 1'b0;
                if (i_wr) begin
                    r_act <= i_cfg;
                end else if (r_pend_v) begin
                    r_act <= r_pend;
                end else if (r_act.mode == LED_ONESHOT) begin
                    r_act.mode <= LED_OFF;
                end
            end else begin
                if (i_step) begin
                    r_phase <= r_phase + CNT_W'(1);
                end
                if (i_wr) begin
                    r_pend   <= i_cfg;
                    r_pend_v <= 1'b1;
                end
            end
        end
    end

    assign o_led = r_led;

endmodule

// File: rtl/led_blink_ctrl.sv
// Multi-channel programmable LED blinker: shared prescaler, config decode and
// per-channel instances. Optional SYNC input under LED_BLINK_SYNC_EN.
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter  int CLK_HZ   = 40_000_000,
    parameter  int TICK_HZ  = 1_000,
    parameter  int CHANNELS = 8,
    parameter  int CNT_W    = 16,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                EN,
    input  logic                CFG_WE,
    input  logic [CH_W-1:0]     CFG_CH,
    input  logic [1:0]          CFG_MODE,
    input  logic [CNT_W-1:0]    CFG_PERIOD,
    input  logic [CNT_W-1:0]    CFG_ON,
`ifdef LED_BLINK_SYNC_EN
    input  logic                SYNC,
`endif
    output logic [CHANNELS-1:0] LED,
    output logic                TICK
);

    localparam int PRE_DIV = pre_div_calc(CLK_HZ, TICK_HZ);
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;

    if (PRE_DIV < 2) begin : g_bad_div
        $error("led_blink_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_chan
        $error("led_blink_ctrl: CHANNELS must be 1..32");
    end

    logic [PRE_W-1:0]    r_pre;
    logic                r_tick;
    logic                w_sync;
    logic                w_step;
    chan_cfg_t           w_cfg;
    logic [CHANNELS-1:0] w_led;

`ifdef LED_BLINK_SYNC_EN
    assign w_sync = SYNC;
`else
    assign w_sync = 1'b0;
`endif

    // With EN low everything freezes, including a tick already pending.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (w_sync) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (EN) begin
            if (r_pre == PRE_W'(PRE_DIV - 1)) begin
                r_pre  <= '0;
                r_tick <= 1'b1;
            end else begin
                r_pre  <= r_pre + PRE_W'(1);
                r_tick <= 1'b0;
            end
        end
    end

    assign w_step = r_tick & EN;
    assign TICK   = w_step;

    assign w_cfg = '{mode: led_mode_t'(CFG_MODE), period: CFG_W'(CFG_PERIOD), on: CFG_W'(CFG_ON)};

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic w_wr;
        assign w_wr = CFG_WE && (CFG_CH == CH_W'(g));

        led_blink_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .i_clk   (CLK),
            .i_rst_n (RESET),
            .i_step  (w_step),
            .i_sync  (w_sync),
            .i_wr    (w_wr),
            .i_cfg   (w_cfg),
            .o_led   (w_led[g])
        );
    end

    assign LED = w_led;

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Bench for led_blink_ctrl (PRE_DIV=10, 4 channels): tick-count reference model
// checked every cycle, plus hand-computed waveform timings.
module tb_led_blink_ctrl;

  localparam int CH  = 4;
  localparam int PRE = 10;

  logic       CLK = 1'b0;
  logic       RESET, EN, CFG_WE;
  logic [1:0] CFG_CH, CFG_MODE;
  logic [7:0] CFG_PERIOD, CFG_ON;
  logic [3:0] LED;
  logic       TICK;

  int vectors = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  led_blink_ctrl #(
    .CLK_HZ   (1000),
    .TICK_HZ  (100),
    .CHANNELS (4),
    .CNT_W    (8)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .EN         (EN),
    .CFG_WE     (CFG_WE),
    .CFG_CH     (CFG_CH),
    .CFG_MODE   (CFG_MODE),
    .CFG_PERIOD (CFG_PERIOD),
    .CFG_ON     (CFG_ON),
    .LED        (LED),
    .TICK       (TICK)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a global count of ticks; each channel remembers the tick
  // index at which its phase was last zero, so phase = elapsed ticks mod period.
  int m_mode[CH], m_per[CH], m_on[CH], m_start[CH];
  int p_mode[CH], p_per[CH], p_on[CH];
  bit m_pv[CH];
  int n_en, g_tick;
  logic [3:0] exp_led;
  logic exp_tick;

  function automatic logic led_of(int c);
    int pe;
    if (m_mode[c] == 0) return 1'b0;
    if (m_mode[c] == 1) return 1'b1;
    pe = (m_per[c] == 0) ? 1 : m_per[c];
    return ((g_tick - m_start[c]) % pe) < m_on[c];
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_mode[c] = 0; m_per[c] = 0; m_on[c] = 0; m_start[c] = 0;
      p_mode[c] = 0; p_per[c] = 0; p_on[c] = 0; m_pv[c] = 0;
    end
    n_en = 0; g_tick = 0; exp_led = '0; exp_tick = 1'b0;
  endtask

  task automatic model_edge();
    bit step, wr;
    int pe;
    step = EN && (n_en > 0) && ((n_en % PRE) == 0);
    for (int c = 0; c < CH; c++) exp_led[c] = led_of(c);
    for (int c = 0; c < CH; c++) begin
      wr = CFG_WE && (int'(CFG_CH) == c);
      pe = (m_per[c] == 0) ? 1 : m_per[c];
      if (m_mode[c] == 0) begin
        if (wr) begin m_mode[c] = int'(CFG_MODE); m_per[c] = int'(CFG_PERIOD); m_on[c] = int'(CFG_ON); end
        m_start[c] = g_tick + int'(step);
        m_pv[c] = 0;
      end else if (step && (((g_tick - m_start[c] + 1) % pe) == 0)) begin
        m_start[c] = g_tick + 1;
        if (wr) begin
          m_mode[c] = int'(CFG_MODE); m_per[c] = int'(CFG_PERIOD); m_on[c] = int'(CFG_ON);
        end else if (m_pv[c]) begin
          m_mode[c] = p_mode[c]; m_per[c] = p_per[c]; m_on[c] = p_on[c];
        end else if (m_mode[c] == 3) begin
          m_mode[c] = 0;
        end
        m_pv[c] = 0;
      end else if (wr) begin
        p_mode[c] = int'(CFG_MODE); p_per[c] = int'(CFG_PERIOD); p_on[c] = int'(CFG_ON);
        m_pv[c] = 1;
      end
    end
    g_tick += int'(step);
    if (EN) n_en++;
    exp_tick = EN && (n_en > 0) && ((n_en % PRE) == 0);
  endtask

  // Compare process: model advances on each edge, DUT sampled 2 time units later.
  always @(posedge CLK) begin
    if (!RESET) model_reset();
    else model_edge();
    #2;
    check("led", {28'd0, LED}, {28'd0, exp_led});
    check("tick", {31'd0, TICK}, {31'd0, exp_tick});
  end

  // Driver tasks
  task automatic cfg_write(input int ch, input int mode, input int per, input int on);
    @(negedge CLK);
    CFG_WE = 1'b1; CFG_CH = 2'(ch); CFG_MODE = 2'(mode); CFG_PERIOD = 8'(per); CFG_ON = 8'(on);
    @(negedge CLK);
    CFG_WE = 1'b0;
  endtask

  task automatic wait_tick();
    int k = 0;
    do begin @(posedge CLK); #2; k++; end while (!TICK && k < 50);
    if (!TICK) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_len(input int ch, input logic lvl, output int len);
    int k = 0;
    while (LED[ch] !== lvl && k < 400) begin @(posedge CLK); #2; k++; end
    len = 0;
    while (LED[ch] === lvl && len < 400) begin len++; @(posedge CLK); #2; end
  endtask

  task automatic wait_rise(input int ch, output int cyc);
    cyc = 0;
    while (LED[ch] === 1'b1 && cyc < 500) begin @(posedge CLK); #2; cyc++; end
    while (LED[ch] !== 1'b1 && cyc < 500) begin @(posedge CLK); #2; cyc++; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, second, len, c, d, lit1, lit2, lit3;
    RESET = 1'b0; EN = 1'b0; CFG_WE = 1'b0; CFG_CH = '0; CFG_MODE = '0; CFG_PERIOD = '0; CFG_ON = '0;
    repeat (3) @(negedge CLK);
    check("rst_led", {28'd0, LED}, 32'd0);
    check("rst_tick", {31'd0, TICK}, 32'd0);
    EN = 1'b1;
    @(negedge CLK);
    RESET = 1'b1;

    // Tick every 10 enabled cycles, first one 10 cycles after reset release.
    first = 0; second = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge CLK); #2;
      if (TICK) begin
        if (first == 0) first = i;
        else if (second == 0) second = i;
      end
    end
    check("tick_first", first, 10);
    check("tick_second", second, 20);

    // BLINK P=4 ON=2 written tick-aligned while OFF: 20 lit / 20 dark.
    wait_tick();
    cfg_write(0, 2, 4, 2);
    run_len(0, 1'b1, len); check("blink_hi1", len, 20);
    run_len(0, 1'b0, len); check("blink_lo1", len, 20);
    run_len(0, 1'b1, len); check("blink_hi2", len, 20);

    // Re-program while running: lands at the boundary, then 10 lit / 50 dark.
    cfg_write(0, 2, 6, 1);
    run_len(0, 1'b1, len); check("reprog_hi", len, 10);
    run_len(0, 1'b0, len); check("reprog_lo", len, 50);

    // ONESHOT P=3 ON=3: 30 lit then OFF; BLINK ON=0 dark; ON with period 0 lit.
    wait_tick();
    cfg_write(1, 3, 3, 3);
    run_len(1, 1'b1, len); check("oneshot_hi", len, 30);
    cfg_write(2, 2, 5, 0);
    cfg_write(3, 1, 0, 0);
    lit1 = 0; lit2 = 0; lit3 = 0;
    for (int i = 0; i < 120; i++) begin
      @(posedge CLK); #2;
      lit1 += int'(LED[1]); lit2 += int'(LED[2]); lit3 += int'(LED[3]);
    end
    check("oneshot_dark", lit1, 0);
    check("on0_dark", lit2, 0);
    check("on_lit", lit3, 120);
    cfg_write(1, 2, 2, 1);
    @(posedge CLK); #2;
    check("oneshot_off_apply", {31'd0, LED[1]}, 32'd1);

    // EN low for 37 cycles mid-period shifts the 60-cycle rise spacing to 97.
    wait_rise(0, d);
    c = 0;
    repeat (20) begin @(posedge CLK); c++; end
    @(negedge CLK); EN = 1'b0;
    repeat (37) begin @(posedge CLK); c++; end
    @(negedge CLK); EN = 1'b1;
    wait_rise(0, d);
    check("en_freeze_shift", c + d, 97);

    // Random traffic checked by the model every cycle.
    repeat (800) begin
      @(negedge CLK);
      EN = ($urandom_range(0, 7) != 0);
      CFG_WE = ($urandom_range(0, 5) == 0);
      CFG_CH = ($urandom_range(0, 3) == 0) ? 2'd0 : 2'($urandom_range(0, 3));
      CFG_MODE = 2'($urandom_range(0, 3));
      CFG_PERIOD = 8'($urandom_range(0, 7));
      CFG_ON = 8'($urandom_range(0, 8));
    end
    @(negedge CLK); CFG_WE = 1'b0; EN = 1'b1;

    // Force ch3 to ON, then assert reset mid-cycle: LED clears at once.
    cfg_write(3, 1, 0, 0);
    repeat (90) @(posedge CLK);
    #2;
    check("pre_reset_on", {31'd0, LED[3]}, 32'd1);
    @(negedge CLK); #3;
    RESET = 1'b0;
    #1;
    check("async_rst_led", {28'd0, LED}, 32'd0);
    check("async_rst_tick", {31'd0, TICK}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    repeat (300) begin
      @(negedge CLK);
      EN = ($urandom_range(0, 9) != 0);
      CFG_WE = ($urandom_range(0, 7) == 0);
      CFG_CH = 2'($urandom_range(0, 3));
      CFG_MODE = 2'($urandom_range(0, 3));
      CFG_PERIOD = 8'($urandom_range(0, 6));
      CFG_ON = 8'($urandom_range(0, 7));
    end
    @(negedge CLK); CFG_WE = 1'b0;
    repeat (3) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
